// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake bundle between a client and the SRAM front-end controller.
// The client drives requests and response backpressure; the controller drives credit and read data.
interface sram_req_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Port-0 front end for a 1RW1R SRAM macro: array clear after reset, credit-based request
// acceptance, registered macro pins and an in-order read response FIFO.
module sram_req_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WMASKS = 4,
    parameter int                    RSP_DEPTH  = 4,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_req_ctrl_if.slave        bus,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
    localparam logic [CW-1:0]         CNT_FULL  = CW'(RSP_DEPTH);
    localparam logic [CW:0]           CREDITS   = (CW+1)'(RSP_DEPTH);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  init_addr_r, init_addr_s;
    logic                   init_last_r, init_last_s;
    logic [1:0]             rd_tag_r, rd_tag_s;
    logic [DATA_WIDTH-1:0]  fifo_mem_r [RSP_DEPTH];
    logic [PW-1:0]          wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CW-1:0]          count_r, count_s;
    logic [CW:0]            outstanding_s;
    logic                   accept_s, push_s, pop_s;
    logic                   csb_r, csb_s, web_r, web_s;
    logic [NUM_WMASKS-1:0]  wmask_r, wmask_s;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
    logic [DATA_WIDTH-1:0]  din_r, din_s;
    logic                   req_ready_r, req_ready_s;
    logic                   rsp_valid_r, rsp_valid_s;
    logic [DATA_WIDTH-1:0]  rsp_rdata_r, rsp_rdata_s;
    logic                   init_done_r, init_done_s;

    // Next-state, macro pin and response FIFO bookkeeping
    always_comb begin
        state_s     = state_r;
        init_addr_s = init_addr_r;
        init_last_s = init_last_r;
        csb_s       = 1'b1;
        web_s       = 1'b1;
        wmask_s     = {NUM_WMASKS{1'b0}};
        addr_s      = addr_r;
        din_s       = din_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (init_last_r) begin
                    state_s     = ST_RUN;
                    init_last_s = 1'b0;
                end else begin
                    csb_s       = 1'b0;
                    web_s       = 1'b0;
                    wmask_s     = {NUM_WMASKS{1'b1}};
                    addr_s      = init_addr_r;
                    din_s       = INIT_VALUE;
                    init_addr_s = init_addr_r + ADDR_ONE;
                    init_last_s = (init_addr_r == ADDR_LAST);
                end
            end
            ST_RUN: begin
                accept_s = bus.req_valid && req_ready_r;
                if (accept_s) begin
                    csb_s   = 1'b0;
                    web_s   = ~bus.req_we;
                    addr_s  = bus.req_addr;
                    din_s   = bus.req_wdata;
                    wmask_s = bus.req_we ? bus.req_wmask : {NUM_WMASKS{1'b0}};
                end else begin
                    csb_s   = 1'b1;
                    web_s   = 1'b1;
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase

        // Read tags follow the macro: sampled one cycle after accept, dout valid one after that
        rd_tag_s = {rd_tag_r[0], accept_s && !bus.req_we};
        push_s   = rd_tag_r[1];
        pop_s    = rsp_valid_r && bus.rsp_ready;
        count_s  = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
        wr_ptr_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

        outstanding_s = {{CW{1'b0}}, rd_tag_s[0]} + {{CW{1'b0}}, rd_tag_s[1]} + {1'b0, count_s};
        req_ready_s   = (state_s == ST_RUN) && (outstanding_s < CREDITS);
        rsp_valid_s   = (count_s != {CW{1'b0}});
        init_done_s   = (state_s == ST_RUN);

        // Head register only moves when the head entry changes
        if (count_s == {CW{1'b0}}) begin
            rsp_rdata_s = rsp_rdata_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
            rsp_rdata_s = sram_dout0;
        end else begin
            rsp_rdata_s = fifo_mem_r[rd_ptr_s];
        end
    end

    // State, pin and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= INIT_EN ? ST_INIT : ST_RUN;
            init_addr_r <= {ADDR_WIDTH{1'b0}};
            init_last_r <= 1'b0;
            rd_tag_r    <= 2'b00;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            csb_r       <= 1'b1;
            web_r       <= 1'b1;
            wmask_r     <= {NUM_WMASKS{1'b0}};
            addr_r      <= {ADDR_WIDTH{1'b0}};
            din_r       <= {DATA_WIDTH{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            init_addr_r <= init_addr_s;
            init_last_r <= init_last_s;
            rd_tag_r    <= rd_tag_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            csb_r       <= csb_s;
            web_r       <= web_s;
            wmask_r     <= wmask_s;
            addr_r      <= addr_s;
            din_r       <= din_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            init_done_r <= init_done_s;
        end
    end

    // Response FIFO storage; pointers alone define validity, so no reset needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= sram_dout0;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign init_done     = init_done_r;
    assign sram_csb0     = csb_r;
    assign sram_web0     = web_r;
    assign sram_wmask0   = wmask_r;
    assign sram_addr0    = addr_r;
    assign sram_din0     = din_r;

    sram_req_ctrl_chk #(.CW(CW), .RSP_DEPTH(RSP_DEPTH)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );
endmodule

// Credit accounting must never let a read land in a full FIFO unless the head leaves too.
module sram_req_ctrl_chk #(
    parameter int CW        = 3,
    parameter int RSP_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CW'(RSP_DEPTH))));
endmodule
